// File: rtl/vendor_multi_if.sv
// vendor_multi_if: front-end / driver-board bundle for the vending controller.
//   master : coin/keypad front end. Drives product, select, coin, drop_coin, check, cancel,
//            drop_product, restock and restock_qty. Observes the controller outputs.
//   slave  : vendor_multi. Drives motor, LED, credit, change_valid, change_amt, coin_reject,
//            sold_out and stock_empty.
interface vendor_multi_if #(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned MONEY_W      = 9,
  parameter int unsigned STOCK_W      = 4
);
  localparam int unsigned PROD_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  logic [PROD_W-1:0]       product;
  logic                    select;
  logic [1:0]              coin;
  logic                    drop_coin;
  logic                    check;
  logic                    cancel;
  logic                    drop_product;
  logic                    restock;
  logic [STOCK_W-1:0]      restock_qty;
  logic                    motor;
  logic [2:0]              LED;
  logic [MONEY_W-1:0]      credit;
  logic                    change_valid;
  logic [MONEY_W-1:0]      change_amt;
  logic                    coin_reject;
  logic                    sold_out;
  logic [NUM_PRODUCTS-1:0] stock_empty;

  modport master (
    output product, select, coin, drop_coin, check, cancel, drop_product, restock, restock_qty,
    input  motor, LED, credit, change_valid, change_amt, coin_reject, sold_out, stock_empty
  );

  modport slave (
    input  product, select, coin, drop_coin, check, cancel, drop_product, restock, restock_qty,
    output motor, LED, credit, change_valid, change_amt, coin_reject, sold_out, stock_empty
  );
endinterface

// File: rtl/vendor_multi.sv
// vendor_multi: multi-product vending controller with per-product price and stock, credit
// ceiling, cancel, inactivity timeout and change return. All outputs are registered.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : vendor_multi_if.slave (strobes in; motor, LED state code, credit, change and
//           status pulses out)
module vendor_multi #(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned MONEY_W      = 9,
  parameter logic [NUM_PRODUCTS*MONEY_W-1:0] PRICES =
    {9'd150, 9'd100, 9'd50, 9'd10},
  parameter logic [4*MONEY_W-1:0] COIN_VALUES =
    {9'd100, 9'd50, 9'd20, 9'd10},
  parameter int unsigned MAX_CREDIT   = 250,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned INIT_STOCK   = 8,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic          clk,
  input  logic          reset,
  vendor_multi_if.slave bus
);
  localparam int unsigned PROD_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_VEND    = 3'd3,
    S_SHORT   = 3'd4,
    S_REFUND  = 3'd5
  } state_e;

  state_e                                state_q, state_d;
  logic [PROD_W-1:0]                     cur_q, cur_d;
  logic [MONEY_W-1:0]                    credit_q, credit_d;
  logic [NUM_PRODUCTS-1:0][STOCK_W-1:0]  stock_q, stock_d;
  logic [TMR_W-1:0]                      tmr_q, tmr_d;
  logic                                  motor_q, motor_d;
  logic                                  change_valid_q, change_valid_d;
  logic [MONEY_W-1:0]                    change_amt_q, change_amt_d;
  logic                                  coin_reject_q, coin_reject_d;
  logic                                  sold_out_q, sold_out_d;
  logic [NUM_PRODUCTS-1:0]               stock_empty_q, stock_empty_d;

  logic                                  prod_ok;
  logic [STOCK_W-1:0]                    sel_stock;
  logic [MONEY_W-1:0]                    coin_val;
  logic [MONEY_W-1:0]                    price_cur;
  logic [MONEY_W:0]                      coin_sum;
  logic                                  coin_fits;
  logic                                  tmr_hit;

  assign prod_ok   = 32'(bus.product) < NUM_PRODUCTS;
  assign sel_stock = prod_ok ? stock_q[bus.product] : '0;
  assign coin_val  = COIN_VALUES[bus.coin*MONEY_W +: MONEY_W];
  assign price_cur = PRICES[cur_q*MONEY_W +: MONEY_W];
  // One extra bit so the ceiling test cannot be fooled by wrap-around.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits = coin_sum <= (MONEY_W+1)'(MAX_CREDIT);
  assign tmr_hit   = tmr_q == TMR_W'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_q          <= '0;
      credit_q       <= '0;
      tmr_q          <= '0;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      motor_q        <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      sold_out_q     <= 1'b0;
      stock_empty_q  <= (INIT_STOCK == 0) ? '1 : '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      credit_q       <= credit_d;
      tmr_q          <= tmr_d;
      stock_q        <= stock_d;
      motor_q        <= motor_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      sold_out_q     <= sold_out_d;
      stock_empty_q  <= stock_empty_d;
    end
  end

  // Timer defaults to zero, so every state change and every accepted strobe restarts it.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    tmr_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.select && prod_ok && sel_stock != '0) begin
          cur_d   = bus.product;
          state_d = S_COLLECT;
        end
        if (bus.restock && prod_ok) stock_d[bus.product] = bus.restock_qty;
      end
      S_COLLECT: begin
        if (bus.cancel) begin
          state_d = S_REFUND;
        end else begin
          // A coin alongside check is credited before CHECK evaluates it.
          if (bus.drop_coin && coin_fits) credit_d = coin_sum[MONEY_W-1:0];
          if (bus.check)                       state_d = S_CHECK;
          else if (bus.drop_coin && coin_fits) tmr_d   = '0;
          else if (tmr_hit)                    state_d = S_REFUND;
          else                                 tmr_d   = tmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (credit_q >= price_cur) begin
          credit_d = credit_q - price_cur;
          if (stock_q[cur_q] != '0) stock_d[cur_q] = stock_q[cur_q] - 1'b1;
          state_d  = S_VEND;
        end else begin
          state_d  = S_SHORT;
        end
      end
      S_SHORT: begin
        if (bus.cancel)     state_d = S_REFUND;
        else if (bus.check) state_d = S_COLLECT;
        else if (tmr_hit)   state_d = S_REFUND;
        else                tmr_d   = tmr_q + 1'b1;
      end
      S_VEND: begin
        if (bus.drop_product) state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
      end
      S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    motor_d        = state_d == S_VEND;
    change_valid_d = (state_q == S_REFUND) && (credit_q != '0);
    change_amt_d   = change_valid_d ? credit_q : '0;
    // Coins are only taken in COLLECT, within the ceiling, and not alongside cancel.
    coin_reject_d  = bus.drop_coin && !((state_q == S_COLLECT) && !bus.cancel && coin_fits);
    sold_out_d     = (state_q == S_IDLE) && bus.select && (!prod_ok || sel_stock == '0);
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) stock_empty_d[i] = stock_d[i] == '0;
  end

  assign bus.motor        = motor_q;
  assign bus.LED          = state_q;
  assign bus.credit       = credit_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.stock_empty  = stock_empty_q;
endmodule

// File: tb/tb_vendor_multi.sv
// tb_vendor_multi: directed bench for vendor_multi (default prices/coins/timeout).
module tb_vendor_multi;
  localparam int unsigned TO = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  vendor_multi_if #(.NUM_PRODUCTS(4), .MONEY_W(9), .STOCK_W(4)) bus();

  vendor_multi #(.NUM_PRODUCTS(4), .MONEY_W(9), .MAX_CREDIT(250), .STOCK_W(4),
                 .INIT_STOCK(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_select(input logic [1:0] p);
    bus.product = p; bus.select = 1'b1; tick(); bus.select = 1'b0;
  endtask
  task automatic do_coin(input logic [1:0] c);
    bus.coin = c; bus.drop_coin = 1'b1; tick(); bus.drop_coin = 1'b0;
  endtask
  task automatic do_check();
    bus.check = 1'b1; tick(); bus.check = 1'b0;
  endtask
  task automatic do_cancel();
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
  endtask
  task automatic do_drop();
    bus.drop_product = 1'b1; tick(); bus.drop_product = 1'b0;
  endtask
  task automatic do_restock(input logic [1:0] p, input logic [3:0] q);
    bus.product = p; bus.restock_qty = q; bus.restock = 1'b1; tick(); bus.restock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    vecs++; if (bus.LED !== 3'd0) begin errs++; $display("FAIL rst_led got=%0d exp=0", bus.LED); end
    vecs++; if (bus.motor !== 1'b0) begin errs++; $display("FAIL rst_motor got=%0b exp=0", bus.motor); end
    vecs++; if (bus.credit !== 9'd0) begin errs++; $display("FAIL rst_credit got=%0d exp=0", bus.credit); end
    vecs++; if (bus.change_valid !== 1'b0 || bus.change_amt !== 9'd0) begin errs++; $display("FAIL rst_change got=%0b/%0d exp=0/0", bus.change_valid, bus.change_amt); end
    vecs++; if (bus.coin_reject !== 1'b0 || bus.sold_out !== 1'b0) begin errs++; $display("FAIL rst_pulses got=%0b%0b exp=00", bus.coin_reject, bus.sold_out); end
    vecs++; if (bus.stock_empty !== 4'b0000) begin errs++; $display("FAIL rst_stock_empty got=%b exp=0000", bus.stock_empty); end
    reset = 1'b0;
  endtask

  task automatic test_vend_exact();
    do_select(2'd0);
    vecs++; if (bus.LED !== 3'd1) begin errs++; $display("FAIL t1_collect got=%0d exp=1", bus.LED); end
    do_coin(2'd0);
    vecs++; if (bus.credit !== 9'd10) begin errs++; $display("FAIL t1_credit got=%0d exp=10", bus.credit); end
    do_check();
    vecs++; if (bus.LED !== 3'd2) begin errs++; $display("FAIL t1_check got=%0d exp=2", bus.LED); end
    tick();
    vecs++; if (bus.LED !== 3'd3 || bus.motor !== 1'b1) begin errs++; $display("FAIL t1_vend got=%0d/%0b exp=3/1", bus.LED, bus.motor); end
    vecs++; if (bus.credit !== 9'd0) begin errs++; $display("FAIL t1_vend_credit got=%0d exp=0", bus.credit); end
    do_drop();
    vecs++; if (bus.LED !== 3'd0 || bus.motor !== 1'b0) begin errs++; $display("FAIL t1_idle got=%0d/%0b exp=0/0", bus.LED, bus.motor); end
    tick();
    vecs++; if (bus.change_valid !== 1'b0) begin errs++; $display("FAIL t1_no_change got=%0b exp=0", bus.change_valid); end
  endtask

  task automatic test_change();
    do_select(2'd3); do_coin(2'd3); do_coin(2'd3);
    vecs++; if (bus.credit !== 9'd200) begin errs++; $display("FAIL t2_credit got=%0d exp=200", bus.credit); end
    do_check(); tick();
    vecs++; if (bus.LED !== 3'd3 || bus.credit !== 9'd50) begin errs++; $display("FAIL t2_vend got=%0d/%0d exp=3/50", bus.LED, bus.credit); end
    do_drop();
    vecs++; if (bus.LED !== 3'd5) begin errs++; $display("FAIL t2_refund got=%0d exp=5", bus.LED); end
    tick();
    vecs++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 9'd50) begin errs++; $display("FAIL t2_change got=%0b/%0d exp=1/50", bus.change_valid, bus.change_amt); end
    vecs++; if (bus.LED !== 3'd0 || bus.credit !== 9'd0) begin errs++; $display("FAIL t2_idle got=%0d/%0d exp=0/0", bus.LED, bus.credit); end
    tick();
    vecs++; if (bus.change_valid !== 1'b0) begin errs++; $display("FAIL t2_pulse_len got=%0b exp=0", bus.change_valid); end
  endtask

  task automatic test_short();
    do_select(2'd2); do_coin(2'd2); do_check(); tick();
    vecs++; if (bus.LED !== 3'd4 || bus.credit !== 9'd50) begin errs++; $display("FAIL t3_short got=%0d/%0d exp=4/50", bus.LED, bus.credit); end
    do_coin(2'd0);
    vecs++; if (bus.coin_reject !== 1'b1 || bus.credit !== 9'd50) begin errs++; $display("FAIL t3_short_coin got=%0b/%0d exp=1/50", bus.coin_reject, bus.credit); end
    do_check();
    vecs++; if (bus.LED !== 3'd1) begin errs++; $display("FAIL t3_retry got=%0d exp=1", bus.LED); end
    bus.coin = 2'd2; bus.drop_coin = 1'b1; bus.check = 1'b1; tick();
    bus.drop_coin = 1'b0; bus.check = 1'b0;
    vecs++; if (bus.LED !== 3'd2 || bus.credit !== 9'd100) begin errs++; $display("FAIL t3_coin_check got=%0d/%0d exp=2/100", bus.LED, bus.credit); end
    tick();
    vecs++; if (bus.LED !== 3'd3 || bus.credit !== 9'd0 || bus.motor !== 1'b1) begin errs++; $display("FAIL t3_vend got=%0d/%0d/%0b exp=3/0/1", bus.LED, bus.credit, bus.motor); end
    do_drop();
    vecs++; if (bus.LED !== 3'd0) begin errs++; $display("FAIL t3_idle got=%0d exp=0", bus.LED); end
  endtask

  task automatic test_ceiling();
    do_coin(2'd1);
    vecs++; if (bus.coin_reject !== 1'b1) begin errs++; $display("FAIL t4_idle_coin got=%0b exp=1", bus.coin_reject); end
    tick();
    vecs++; if (bus.coin_reject !== 1'b0) begin errs++; $display("FAIL t4_reject_len got=%0b exp=0", bus.coin_reject); end
    do_select(2'd1); do_coin(2'd3); do_coin(2'd3); do_coin(2'd2);
    vecs++; if (bus.credit !== 9'd250 || bus.coin_reject !== 1'b0) begin errs++; $display("FAIL t4_at_ceiling got=%0d/%0b exp=250/0", bus.credit, bus.coin_reject); end
    do_coin(2'd0);
    vecs++; if (bus.credit !== 9'd250 || bus.coin_reject !== 1'b1) begin errs++; $display("FAIL t4_over got=%0d/%0b exp=250/1", bus.credit, bus.coin_reject); end
    do_cancel();
    vecs++; if (bus.LED !== 3'd5) begin errs++; $display("FAIL t4_cancel got=%0d exp=5", bus.LED); end
    tick();
    vecs++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 9'd250) begin errs++; $display("FAIL t4_change got=%0b/%0d exp=1/250", bus.change_valid, bus.change_amt); end
  endtask

  task automatic test_sold_out();
    do_restock(2'd1, 4'd0);
    vecs++; if (bus.stock_empty !== 4'b0010) begin errs++; $display("FAIL t5_empty got=%b exp=0010", bus.stock_empty); end
    do_select(2'd1);
    vecs++; if (bus.sold_out !== 1'b1 || bus.LED !== 3'd0) begin errs++; $display("FAIL t5_sold_out got=%0b/%0d exp=1/0", bus.sold_out, bus.LED); end
    tick();
    vecs++; if (bus.sold_out !== 1'b0) begin errs++; $display("FAIL t5_pulse_len got=%0b exp=0", bus.sold_out); end
    do_restock(2'd1, 4'd5);
    vecs++; if (bus.stock_empty !== 4'b0000) begin errs++; $display("FAIL t5_restocked got=%b exp=0000", bus.stock_empty); end
    do_select(2'd1);
    vecs++; if (bus.LED !== 3'd1 || bus.sold_out !== 1'b0) begin errs++; $display("FAIL t5_select got=%0d/%0b exp=1/0", bus.LED, bus.sold_out); end
    do_restock(2'd2, 4'd0);
    vecs++; if (bus.stock_empty !== 4'b0000) begin errs++; $display("FAIL t5_restock_busy got=%b exp=0000", bus.stock_empty); end
    bus.coin = 2'd0; bus.drop_coin = 1'b1; bus.cancel = 1'b1; bus.check = 1'b1; tick();
    bus.drop_coin = 1'b0; bus.cancel = 1'b0; bus.check = 1'b0;
    vecs++; if (bus.LED !== 3'd5 || bus.coin_reject !== 1'b1 || bus.credit !== 9'd0) begin errs++; $display("FAIL t5_cancel_prio got=%0d/%0b/%0d exp=5/1/0", bus.LED, bus.coin_reject, bus.credit); end
    tick();
    vecs++; if (bus.LED !== 3'd0 || bus.change_valid !== 1'b0) begin errs++; $display("FAIL t5_zero_refund got=%0d/%0b exp=0/0", bus.LED, bus.change_valid); end
  endtask

  task automatic test_timeout();
    do_select(2'd0); do_coin(2'd1);
    vecs++; if (bus.credit !== 9'd20) begin errs++; $display("FAIL t6_credit got=%0d exp=20", bus.credit); end
    repeat (TO - 1) tick();
    vecs++; if (bus.LED !== 3'd1) begin errs++; $display("FAIL t6_early got=%0d exp=1", bus.LED); end
    tick();
    vecs++; if (bus.LED !== 3'd5) begin errs++; $display("FAIL t6_expire got=%0d exp=5", bus.LED); end
    tick();
    vecs++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 9'd20 || bus.LED !== 3'd0) begin errs++; $display("FAIL t6_change got=%0b/%0d/%0d exp=1/20/0", bus.change_valid, bus.change_amt, bus.LED); end
  endtask

  task automatic test_reset_abort();
    do_select(2'd0); do_coin(2'd1); tick(); tick();
    reset = 1'b1; tick();
    vecs++; if (bus.LED !== 3'd0 || bus.credit !== 9'd0 || bus.change_valid !== 1'b0) begin errs++; $display("FAIL t6_reset got=%0d/%0d/%0b exp=0/0/0", bus.LED, bus.credit, bus.change_valid); end
    reset = 1'b0; tick();
    vecs++; if (bus.change_valid !== 1'b0 || bus.LED !== 3'd0) begin errs++; $display("FAIL t6_after_reset got=%0b/%0d exp=0/0", bus.change_valid, bus.LED); end
  endtask

  initial begin
    bus.product = '0; bus.select = 1'b0; bus.coin = '0; bus.drop_coin = 1'b0;
    bus.check = 1'b0; bus.cancel = 1'b0; bus.drop_product = 1'b0;
    bus.restock = 1'b0; bus.restock_qty = '0;
    test_reset();
    test_vend_exact();
    test_change();
    test_short();
    test_ceiling();
    test_sold_out();
    test_timeout();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
